sframe_port: RTL and testbench

Parametrised serial-frame endpoint for the register-bank link. In transmit mode it reads DEPTH words from its local register bank and serialises each as an address+data frame on `sen`/`sd`. In receive mode it deserialises frames and writes them into its bank. One instance per side replaces the fixed-width S1/S2 pair: the upload (3+18) and download (5+8) framings become parameter sets of the same block, and frame-error detection is added.

---
 rtl/sframe_port_if.sv | 25 ++
 rtl/sframe_port.sv | 226 ++++++++++++++++++++++
 tb/tb_sframe_port.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sframe_port_if.sv
// sframe_port_if: register-bank bus between sframe_port and its bank.
// master drives address/data/write-enable, slave returns read data.
interface sframe_port_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          RB_RW;
  logic [AW-1:0] RB_A;
  logic [DW-1:0] RB_D;
  logic [DW-1:0] RB_Q;

  modport master (
    output RB_RW,
    output RB_A,
    output RB_D,
    input  RB_Q
  );

  modport slave (
    input  RB_RW,
    input  RB_A,
    input  RB_D,
    output RB_Q
  );
endinterface

// File: rtl/sframe_port.sv
// sframe_port: serial address+data frame endpoint for the register-bank link.
// Define SFRAME_PARITY_EN to append/check an even-parity bit per frame.
module sframe_port #(
  parameter int   AW       = 5,
  parameter int   DW       = 8,
  parameter int   DEPTH    = 18,
  parameter logic TX_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          updown,
  output logic          done,
  sframe_port_if.master rb,
  input  logic          sen_i,
  input  logic          sd_i,
  output logic          sen_o,
  output logic          sd_o,
  output logic          rx_err,
  output logic [7:0]    err_cnt
);

`ifdef SFRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F  = AW + DW + PB;
  localparam int CW = $clog2(F + 1);

  localparam logic [CW-1:0] FC   = CW'(F);
  localparam logic [CW-1:0] FC1  = CW'(F - 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   DLIM = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_SHIFT,
    S_WR,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          dir_q;
  logic [AW-1:0] k_q;
  logic [AW:0]   acc_q;
  logic [CW-1:0] cnt_q;
  logic          skip_q;
  logic [F-1:0]  tx_sh_q;
  logic [F-2:0]  rx_sh_q;
  logic          sen_q;
  logic          sd_q;
  logic          rw_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    ecnt_q;

  logic          tx_mode_d;
  logic [F-1:0]  tx_frame_d;
  logic [F-1:0]  rx_frame_d;
  logic [AW-1:0] rx_addr_d;
  logic [DW-1:0] rx_data_d;
  logic          rx_bad_d;
  logic [7:0]    ecnt_d;

  // Frame assembly for both directions and the receive-side validity check.
  always_comb begin
    tx_mode_d = (dir_q == TX_LEVEL);
`ifdef SFRAME_PARITY_EN
    tx_frame_d = {k_q, rb.RB_Q, ^{k_q, rb.RB_Q}};
`else
    tx_frame_d = {k_q, rb.RB_Q};
`endif
    rx_frame_d = {rx_sh_q, sd_i};
    rx_addr_d  = rx_frame_d[F-1 -: AW];
    rx_data_d  = rx_frame_d[F-1-AW -: DW];
    rx_bad_d   = ({1'b0, rx_addr_d} >= DLIM);
`ifdef SFRAME_PARITY_EN
    if (^rx_frame_d) begin
      rx_bad_d = 1'b1;
    end
`endif
    ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
  end

  // Transfer FSM: TX reads and serialises, RX deserialises and writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= updown;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      sen_q   <= 1'b1;
      sd_q    <= 1'b0;
      rw_q    <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else if (updown != dir_q) begin
      // Role change drops any frame in flight; error history survives.
      dir_q   <= updown;
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      sen_q   <= 1'b1;
      sd_q    <= 1'b0;
      rw_q    <= 1'b1;
      a_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rw_q  <= 1'b1;
      err_q <= 1'b0;
      if (tx_mode_d) begin
        unique case (state_q)
          S_IDLE: begin
            a_q     <= k_q;
            state_q <= S_RD;
          end
          S_RD: begin
            state_q <= S_LOAD;
          end
          S_LOAD: begin
            tx_sh_q <= tx_frame_d << 1;
            sd_q    <= tx_frame_d[F-1];
            sen_q   <= 1'b0;
            cnt_q   <= CW'(1);
            state_q <= S_SHIFT;
          end
          S_SHIFT: begin
            if (cnt_q == FC) begin
              sen_q <= 1'b1;
              sd_q  <= 1'b0;
              cnt_q <= '0;
              if (k_q == LAST) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                k_q     <= k_q + 1'b1;
                a_q     <= k_q + 1'b1;
                state_q <= S_RD;
              end
            end else begin
              sd_q    <= tx_sh_q[F-1];
              tx_sh_q <= tx_sh_q << 1;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            sen_q <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end else begin
        unique case (state_q)
          S_IDLE, S_WR: begin
            if (state_q == S_WR) begin
              if (acc_q == DLIM) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= S_IDLE;
              end
            end
            if (sen_i) begin
              // Frame gap: a partial frame ending here is short.
              skip_q <= 1'b0;
              cnt_q  <= '0;
              if (cnt_q != '0) begin
                err_q  <= 1'b1;
                ecnt_q <= ecnt_d;
              end
            end else if (!skip_q) begin
              if (cnt_q == FC1) begin
                cnt_q  <= '0;
                skip_q <= 1'b1;
                if (rx_bad_d) begin
                  err_q  <= 1'b1;
                  ecnt_q <= ecnt_d;
                end else begin
                  rw_q    <= 1'b0;
                  a_q     <= rx_addr_d;
                  d_q     <= rx_data_d;
                  acc_q   <= acc_q + 1'b1;
                  state_q <= S_WR;
                end
              end else begin
                rx_sh_q <= rx_frame_d[F-2:0];
                cnt_q   <= cnt_q + 1'b1;
              end
            end
          end
          S_DONE: begin
            sen_q <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rb.RB_RW = rw_q;
  assign rb.RB_A  = a_q;
  assign rb.RB_D  = d_q;
  assign sen_o    = sen_q;
  assign sd_o     = sd_q;
  assign done     = done_q;
  assign rx_err   = err_q;
  assign err_cnt  = ecnt_q;

endmodule

// File: tb/tb_sframe_port.sv
// tb_sframe_port: two sframe_port instances (5+8 x18 and 3+18 x8)
// driven by vector tables, hand sequences and a random frame model.
module tb_sframe_port;

`ifdef SFRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FA = 13 + PB;
  localparam int FB = 21 + PB;
  localparam int NA = 18;
  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, up_a, sen_i_a, sd_i_a;
  logic       done_a, sen_o_a, sd_o_a, rx_err_a;
  logic [7:0] err_cnt_a;
  logic       rst_b, up_b, sen_i_b, sd_i_b;
  logic       done_b, sen_o_b, sd_o_b, rx_err_b;
  logic [7:0] err_cnt_b;

  sframe_port_if #(.AW(5), .DW(8))  ifa ();
  sframe_port_if #(.AW(3), .DW(18)) ifb ();

  sframe_port #(.AW(5), .DW(8), .DEPTH(NA), .TX_LEVEL(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .updown(up_a), .done(done_a), .rb(ifa),
    .sen_i(sen_i_a), .sd_i(sd_i_a), .sen_o(sen_o_a), .sd_o(sd_o_a),
    .rx_err(rx_err_a), .err_cnt(err_cnt_a)
  );

  sframe_port #(.AW(3), .DW(18), .DEPTH(NB), .TX_LEVEL(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .updown(up_b), .done(done_b), .rb(ifb),
    .sen_i(sen_i_b), .sd_i(sd_i_b), .sen_o(sen_o_b), .sd_o(sd_o_b),
    .rx_err(rx_err_b), .err_cnt(err_cnt_b)
  );

  logic [7:0]  mem_a [32];
  logic [7:0]  img_a [32];
  logic [17:0] mem_b [8];
  logic        load_a = 1'b0;
  int          wr_a = 0, errp_a = 0, wr_b = 0;

  always @(posedge clk) begin
    ifa.RB_Q <= mem_a[ifa.RB_A];
    if (load_a) mem_a <= img_a;
    else if (!ifa.RB_RW) begin
      mem_a[ifa.RB_A] <= ifa.RB_D;
      wr_a++;
    end
    if (rx_err_a) errp_a++;
  end

  always @(posedge clk) begin
    ifb.RB_Q <= mem_b[ifb.RB_A];
    if (!ifb.RB_RW) begin
      mem_b[ifb.RB_A] <= ifb.RB_D;
      wr_b++;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] fa(input logic [4:0] a,
                                     input logic [7:0] d);
    logic [12:0] b;
    b = {a, d};
`ifdef SFRAME_PARITY_EN
    return {50'd0, b, ^b};
`else
    return {51'd0, b};
`endif
  endfunction

  function automatic logic [63:0] fb(input logic [2:0] a,
                                     input logic [17:0] d);
    logic [20:0] b;
    b = {a, d};
`ifdef SFRAME_PARITY_EN
    return {42'd0, b, ^b};
`else
    return {43'd0, b};
`endif
  endfunction

  task automatic load_bank();
    @(negedge clk) load_a = 1'b1;
    @(negedge clk) load_a = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first cycle after reset.
  task automatic reset_a();
    @(negedge clk) rst_a = 1'b1;
    @(negedge clk) rst_a = 1'b0;
  endtask

  task automatic send_a(input logic [63:0] fr, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sen_i_a = 1'b0;
      sd_i_a  = (i < FA) ? fr[FA-1-i] : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    sen_i_a = 1'b1;
    sd_i_a  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Expected TX line per cycle from the transfer timing rules.
  task automatic tx_check(input string tag, input int capk,
                          input logic [63:0] capexp);
    logic [3:0]  q[$];
    logic [63:0] fr, cap;
    int          cs;
    q.push_back(4'b1001);
    for (int k = 0; k < NA; k++) begin
      q.push_back(4'b1001);
      q.push_back(4'b1001);
      fr = fa(5'(k), img_a[k]);
      for (int b = FA - 1; b >= 0; b--)
        q.push_back({1'b0, fr[b], 1'b0, 1'b1});
    end
    repeat (3) q.push_back(4'b1011);
    cs  = 1 + capk * (FA + 2) + 2;
    cap = '0;
    for (int c = 0; c < q.size(); c++) begin
      if (c > 0) @(negedge clk);
      if (c >= cs && c < cs + FA) cap = {cap[62:0], sd_o_a};
      chk($sformatf("%s_c%0d", tag, c),
          {60'd0, sen_o_a, sd_o_a, done_a, ifa.RB_RW}, {60'd0, q[c]});
    end
    chk($sformatf("%s_frame%0d", tag, capk), cap, capexp);
  endtask

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         len;
    bit         err;
    bit         wr;
  } vec_t;

  vec_t        tv[9];
  logic [7:0]  mm[32];
  logic [63:0] fr;
  logic [4:0]  ra;
  logic [7:0]  rd;
  int          w0, e0, accm, errm, len, kind;

  initial begin
    rst_a = 1'b1; up_a = 1'b1; sen_i_a = 1'b1; sd_i_a = 1'b0;
    rst_b = 1'b1; up_b = 1'b0; sen_i_b = 1'b1; sd_i_b = 1'b0;

    tv[0] = '{5'd0,  8'h5A, FA,     1'b0, 1'b1};
    tv[1] = '{5'd1,  8'hC3, 6,      1'b1, 1'b0};
    tv[2] = '{5'd1,  8'hC3, FA,     1'b0, 1'b1};
    tv[3] = '{5'd20, 8'h11, FA,     1'b1, 1'b0};
    tv[4] = '{5'd17, 8'hFF, FA + 3, 1'b0, 1'b1};
    tv[5] = '{5'd31, 8'h77, FA,     1'b1, 1'b0};
    tv[6] = '{5'd2,  8'h00, 1,      1'b1, 1'b0};
    tv[7] = '{5'd5,  8'h81, FA - 1, 1'b1, 1'b0};
    tv[8] = '{5'd17, 8'h42, FA,     1'b0, 1'b1};

    // TX with bank[i] = 7i, including reset values and frame 3.
    for (int i = 0; i < 32; i++) img_a[i] = 8'(i * 7);
    load_bank();
    reset_a();
    chk("rst_sen", sen_o_a, 1);
    chk("rst_sd", sd_o_a, 0);
    chk("rst_rw", ifa.RB_RW, 1);
    chk("rst_a", ifa.RB_A, 0);
    chk("rst_d", ifa.RB_D, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rxerr", rx_err_a, 0);
    chk("rst_errcnt", err_cnt_a, 0);
`ifdef SFRAME_PARITY_EN
    tx_check("tx7", 3, {50'd0, 13'b0001100010101, 1'b1});
`else
    tx_check("tx7", 3, {51'd0, 13'b0001100010101});
`endif

    // TX with random bank; frame 1 carries {1, 03}.
    for (int i = 0; i < 32; i++) img_a[i] = 8'($urandom);
    img_a[1] = 8'h03;
    load_bank();
    reset_a();
`ifdef SFRAME_PARITY_EN
    tx_check("txr", 1, {50'd0, 13'b0000100000011, 1'b1});
`else
    tx_check("txr", 1, {51'd0, 13'b0000100000011});
`endif

    // Direction change in the middle of frame 0, SHIFT bit 4.
    reset_a();
    repeat (7) @(negedge clk);
    chk("tog_pre_sen", sen_o_a, 0);
    up_a = 1'b0;
    @(negedge clk);
    chk("tog_sen", sen_o_a, 1);
    chk("tog_done", done_a, 0);
    chk("tog_addr", ifa.RB_A, 0);
    chk("tog_rw", ifa.RB_RW, 1);
    e0 = errp_a;
    send_a(fa(5'd4, 8'h00), 4);
    chk("tog_short_err", errp_a - e0, 1);
    chk("tog_errcnt", err_cnt_a, 1);
    w0 = wr_a;
    send_a(fa(5'd4, 8'h9C), FA);
    chk("tog_rx_wr", wr_a - w0, 1);
    chk("tog_rx_data", mem_a[4], 8'h9C);
    img_a[4] = 8'h9C;
    up_a = 1'b1;
    @(negedge clk);
    chk("tog_keep_err", err_cnt_a, 1);
    tx_check("txt", 0, fa(5'd0, img_a[0]));

    // RX vector table on the 5+8 instance.
    up_a = 1'b0;
    reset_a();
    for (int i = 0; i < 9; i++) begin
      w0 = wr_a;
      e0 = errp_a;
      send_a(fa(tv[i].a, tv[i].d), tv[i].len);
      chk($sformatf("tv%0d_wr", i), wr_a - w0, tv[i].wr);
      chk($sformatf("tv%0d_err", i), errp_a - e0, tv[i].err);
      if (tv[i].wr)
        chk($sformatf("tv%0d_data", i), mem_a[tv[i].a], tv[i].d);
    end
    chk("tv_errcnt", err_cnt_a, 5);
    chk("tv_done", done_a, 0);

`ifdef SFRAME_PARITY_EN
    w0 = wr_a;
    e0 = errp_a;
    send_a(fa(5'd3, 8'h10) ^ 64'd1, FA);
    chk("par_wr", wr_a - w0, 0);
    chk("par_err", errp_a - e0, 1);
    chk("par_errcnt", err_cnt_a, 6);
`endif

    // Random RX frames against a bank/counter model.
    for (int i = 0; i < 32; i++) begin
      img_a[i] = 8'h00;
      mm[i]    = 8'h00;
    end
    load_bank();
    reset_a();
    accm = 0;
    errm = 0;
    w0   = wr_a;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      ra   = 5'($urandom_range(0, NA - 1));
      rd   = 8'($urandom);
      len  = FA;
      if (kind < 2) len = $urandom_range(1, FA - 1);
      else if (kind == 2) ra = 5'($urandom_range(NA, 31));
      else if (kind == 3) len = FA + $urandom_range(1, 4);
      send_a(fa(ra, rd), len);
      if (accm < NA) begin
        if (len < FA || int'(ra) >= NA) errm = (errm < 255) ? errm + 1 : 255;
        else begin
          mm[ra] = rd;
          accm++;
        end
      end
      chk($sformatf("rnd%0d_errcnt", n), err_cnt_a, errm);
    end
    chk("rnd_done", done_a, accm == NA);
    chk("rnd_writes", wr_a - w0, accm);
    for (int i = 0; i < 32; i++)
      chk($sformatf("rnd_mem%0d", i), mem_a[i], mm[i]);

    // 3+18 instance: 8 frames {i, 3FFFF-i}, write and done timing.
    @(negedge clk) rst_b = 1'b1;
    @(negedge clk) rst_b = 1'b0;
    w0 = wr_b;
    for (int i = 0; i < NB; i++) begin
      fr = fb(3'(i), 18'h3FFFF - 18'(i));
      for (int b = 0; b < FB; b++) begin
        @(negedge clk);
        sen_i_b = 1'b0;
        sd_i_b  = fr[FB-1-b];
      end
      @(negedge clk);
      sen_i_b = 1'b1;
      sd_i_b  = 1'b0;
      chk($sformatf("b%0d_wr_rw", i), ifb.RB_RW, 0);
      chk($sformatf("b%0d_wr_a", i), ifb.RB_A, i);
      chk($sformatf("b%0d_wr_d", i), ifb.RB_D, 18'h3FFFF - 18'(i));
      chk($sformatf("b%0d_wr_done", i), done_b, 0);
      @(negedge clk);
      chk($sformatf("b%0d_post_rw", i), ifb.RB_RW, 1);
      chk($sformatf("b%0d_post_done", i), done_b, i == NB - 1);
      repeat (2) @(negedge clk);
    end
    chk("b_writes", wr_b - w0, NB);
    chk("b_mem7", mem_b[7], 18'h3FFF8);
    for (int i = 0; i < NB; i++)
      chk($sformatf("b_mem%0d", i), mem_b[i], 18'h3FFFF - 18'(i));
    chk("b_done", done_b, 1);
    chk("b_errcnt", err_cnt_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
